// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST sequencer: FSM state encoding,
// polynomial select values and a counter-width helper.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      SIGN    = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic POLY_A = 1'b0;
   localparam logic POLY_B = 1'b1;

   // Width needed to count 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bist_phase_counter.sv
// Nested shift/pattern counter for one BIST phase; flags the last shift cycle
// of a pattern and the last pattern of a phase.
module bist_phase_counter
   import bist_pkg::*;
#(
   parameter int SCAN_LEN   = 8,
   parameter int N_PATTERNS = 64
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic shift_en,
   input  logic pattern_en,
   output logic last_shift,
   output logic last_pattern
);

   localparam int SW = clog2_min1(SCAN_LEN);
   localparam int PW = clog2_min1(N_PATTERNS);
   localparam logic [SW-1:0] SHIFT_MAX   = SW'(SCAN_LEN - 1);
   localparam logic [PW-1:0] PATTERN_MAX = PW'(N_PATTERNS - 1);

   logic [SW-1:0] shift_cnt_reg, shift_cnt_next;
   logic [PW-1:0] pat_cnt_reg, pat_cnt_next;

   assign last_shift   = (shift_cnt_reg == SHIFT_MAX);
   assign last_pattern = (pat_cnt_reg == PATTERN_MAX);

   // Both counters wrap at their terminal value, so neither can overflow.
   always_comb begin
      shift_cnt_next = shift_cnt_reg;
      pat_cnt_next   = pat_cnt_reg;
      if (clear) begin
         shift_cnt_next = '0;
         pat_cnt_next   = '0;
      end else begin
         if (shift_en) begin
            shift_cnt_next = last_shift ? '0 : shift_cnt_reg + 1'b1;
         end
         if (pattern_en) begin
            pat_cnt_next = last_pattern ? '0 : pat_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         shift_cnt_reg <= '0;
         pat_cnt_reg   <= '0;
      end else begin
         shift_cnt_reg <= shift_cnt_next;
         pat_cnt_reg   <= pat_cnt_next;
      end
   end

endmodule

// File: rtl/bist_sequencer.sv
// Two-phase pseudo-random BIST sequencer: seed load plus N_PATTERNS
// shift/capture patterns per LFSR polynomial, then signature strobe.
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int SCAN_LEN   = 8,
   parameter int N_PATTERNS = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic START,
   output logic OUT,
   output logic Seed,
   output logic Poly,
   output logic BIST_END,
   output logic FINISH
);

   state_t state_reg, state_next;
   logic   last_shift, last_pattern;
   logic   out_reg, out_next;
   logic   seed_reg, seed_next;
   logic   poly_reg, poly_next;
   logic   bist_end_reg, bist_end_next;
   logic   finish_reg, finish_next;

   bist_phase_counter #(
      .SCAN_LEN   (SCAN_LEN),
      .N_PATTERNS (N_PATTERNS)
   ) u_counter (
      .clk          (CLK),
      .srst         (RST),
      .clear        (state_reg == IDLE),
      .shift_en     (state_reg == SHIFT),
      .pattern_en   (state_reg == CAPTURE),
      .last_shift   (last_shift),
      .last_pattern (last_pattern)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    state_next = START ? INIT : IDLE;
         INIT:    state_next = SHIFT;
         SHIFT:   state_next = last_shift ? CAPTURE : SHIFT;
         CAPTURE: begin
            if (!last_pattern) begin
               state_next = SHIFT;
            end else if (poly_reg == POLY_A) begin
               state_next = INIT;
            end else begin
               state_next = SIGN;
            end
         end
         SIGN:    state_next = DONE;
         DONE:    state_next = START ? DONE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they are
   // Moore-aligned with state_reg and carry no path from START.
   always_comb begin
      out_next      = (state_next == SHIFT);
      seed_next     = (state_next == INIT);
      finish_next   = (state_next == SIGN);
      bist_end_next = (state_next == SIGN) || (state_next == DONE);
      poly_next     = poly_reg;
      if (state_next == IDLE) begin
         poly_next = POLY_A;
      end else if (state_reg == CAPTURE && state_next == INIT) begin
         poly_next = POLY_B;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_reg      <= 1'b0;
         seed_reg     <= 1'b0;
         poly_reg     <= POLY_A;
         bist_end_reg <= 1'b0;
         finish_reg   <= 1'b0;
      end else begin
         out_reg      <= out_next;
         seed_reg     <= seed_next;
         poly_reg     <= poly_next;
         bist_end_reg <= bist_end_next;
         finish_reg   <= finish_next;
      end
   end

   assign OUT      = out_reg;
   assign Seed     = seed_reg;
   assign Poly     = poly_reg;
   assign BIST_END = bist_end_reg;
   assign FINISH   = finish_reg;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: nominal (4,3) instance plus an edge
// (1,1) instance; vectors are {OUT, Seed, Poly, BIST_END, FINISH}.
module tb_bist_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, start_a, out_a, seed_a, poly_a, end_a, fin_a;
   logic rst_b, start_b, out_b, seed_b, poly_b, end_b, fin_b;

   bist_sequencer #(.SCAN_LEN(4), .N_PATTERNS(3)) dut_a (
      .CLK(clk), .RST(rst_a), .START(start_a), .OUT(out_a), .Seed(seed_a),
      .Poly(poly_a), .BIST_END(end_a), .FINISH(fin_a)
   );

   bist_sequencer #(.SCAN_LEN(1), .N_PATTERNS(1)) dut_b (
      .CLK(clk), .RST(rst_b), .START(start_b), .OUT(out_b), .Seed(seed_b),
      .Poly(poly_b), .BIST_END(end_b), .FINISH(fin_b)
   );

   wire [4:0] vec_a = {out_a, seed_a, poly_a, end_a, fin_a};
   wire [4:0] vec_b = {out_b, seed_b, poly_b, end_b, fin_b};

   int checks = 0;
   int errors = 0;
   logic [4:0] trace [0:63];

   // Expected output vector at cycle k after START was sampled at cycle 0,
   // assuming START stays high once the test has finished.
   function automatic logic [4:0] exp_vec(input int k, input int sl, input int np);
      int pl;
      int p;
      logic o, s, py, be, f;
      pl = 1 + np * (sl + 1);
      o = 1'b0; s = 1'b0; py = 1'b0; be = 1'b0; f = 1'b0;
      if (k <= 2 * pl) begin
         p  = (k - 1) % pl;
         s  = (p == 0);
         o  = (p != 0) && ((p % (sl + 1)) != 0);
         py = (k > pl);
      end else begin
         py = 1'b1;
         be = 1'b1;
         f  = (k == 2 * pl + 1);
      end
      return {o, s, py, be, f};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise START on the selected DUT and record ncyc cycles of outputs.
   task automatic run_trace(input bit sel, input int ncyc, input int drop_at);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         trace[k] = sel ? vec_b : vec_a;
         if (k == drop_at) begin
            if (sel) start_b = 1'b0; else start_a = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      step();
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL reset_a got %b want %b", vec_a, 5'b0);
      end
      checks++;
      if (vec_b !== 5'b0) begin
         errors++;
         $display("FAIL reset_b got %b want %b", vec_b, 5'b0);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b want %b", vec_a, 5'b0);
      end
      $display("test_reset: outputs checked after reset and in idle");
   endtask

   task automatic test_nominal();
      int out_rise, seed_cnt, fin_cnt;
      logic prev_out;
      run_trace(1'b0, 36, 0);
      out_rise = 0; seed_cnt = 0; fin_cnt = 0; prev_out = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         checks++;
         if (trace[k] !== exp_vec(k, 4, 3)) begin
            errors++;
            $display("FAIL nominal cycle %0d got %b want %b", k, trace[k], exp_vec(k, 4, 3));
         end
         if (trace[k][4] && !prev_out) out_rise++;
         prev_out = trace[k][4];
         if (trace[k][3]) seed_cnt++;
         if (trace[k][0]) fin_cnt++;
      end
      checks++;
      if (out_rise != 6) begin
         errors++;
         $display("FAIL out_rise_count got %0d want 6", out_rise);
      end
      checks++;
      if (seed_cnt != 2) begin
         errors++;
         $display("FAIL seed_pulse_count got %0d want 2", seed_cnt);
      end
      checks++;
      if (fin_cnt != 1) begin
         errors++;
         $display("FAIL finish_pulse_count got %0d want 1", fin_cnt);
      end
      $display("test_nominal: 36 cycles, out_rise=%0d seed=%0d finish=%0d", out_rise, seed_cnt, fin_cnt);
   endtask

   task automatic test_start_hold();
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if (vec_a !== 5'b00110) begin
            errors++;
            $display("FAIL done_hold cycle %0d got %b want %b", k, vec_a, 5'b00110);
         end
      end
      $display("test_start_hold: 20 cycles in DONE with START high");
   endtask

   task automatic test_restart();
      start_a = 1'b0;
      step();
      step();
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL restart_idle got %b want %b", vec_a, 5'b0);
      end
      start_a = 1'b1;
      step();
      checks++;
      if (vec_a !== 5'b01000) begin
         errors++;
         $display("FAIL restart_init got %b want %b", vec_a, 5'b01000);
      end
      $display("test_restart: idle then fresh INIT with Poly=0");
   endtask

   task automatic test_reset_mid();
      // Currently at cycle 1 of a run; advance to cycle 19 (phase B SHIFT).
      for (int k = 2; k <= 19; k++) step();
      checks++;
      if (vec_a !== exp_vec(19, 4, 3)) begin
         errors++;
         $display("FAIL phase_b_shift got %b want %b", vec_a, exp_vec(19, 4, 3));
      end
      rst_a = 1'b1;
      step();
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid got %b want %b", vec_a, 5'b0);
      end
      rst_a = 1'b0; start_a = 1'b0;
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid_idle got %b want %b", vec_a, 5'b0);
      end
      $display("test_reset_mid: reset during phase B shift");
   endtask

   task automatic test_start_drop();
      run_trace(1'b0, 34, 5);
      for (int k = 1; k <= 34; k++) begin
         checks++;
         if (trace[k] !== exp_vec(k, 4, 3)) begin
            errors++;
            $display("FAIL start_drop cycle %0d got %b want %b", k, trace[k], exp_vec(k, 4, 3));
         end
      end
      step();
      checks++;
      if (vec_a !== 5'b0) begin
         errors++;
         $display("FAIL start_drop_idle got %b want %b", vec_a, 5'b0);
      end
      $display("test_start_drop: START dropped at cycle 5, 34 cycles checked");
   endtask

   task automatic test_edge();
      int fin_cnt;
      run_trace(1'b1, 10, 0);
      fin_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         checks++;
         if (trace[k] !== exp_vec(k, 1, 1)) begin
            errors++;
            $display("FAIL edge cycle %0d got %b want %b", k, trace[k], exp_vec(k, 1, 1));
         end
         if (trace[k][0]) fin_cnt++;
      end
      checks++;
      if (fin_cnt != 1 || trace[7][0] !== 1'b1) begin
         errors++;
         $display("FAIL edge_finish count %0d at7 %b want 1 and 1", fin_cnt, trace[7][0]);
      end
      $display("test_edge: SCAN_LEN=1 N_PATTERNS=1, 10 cycles checked");
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      test_reset();
      test_nominal();
      test_start_hold();
      test_restart();
      test_reset_mid();
      test_start_drop();
      test_edge();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
